// File: rtl/generador_ciclo_rtc_pkg.sv
// Shared definitions for the RTC bus-cycle sequencer: state encoding, default
// phase lengths and the registered output bundle.
package generador_ciclo_rtc_pkg;

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ADDR = 3'd1;
    localparam logic [2:0] ST_HOLD = 3'd2;
    localparam logic [2:0] ST_TURN = 3'd3;
    localparam logic [2:0] ST_DATA = 3'd4;
    localparam logic [2:0] ST_REC  = 3'd5;
    localparam logic [2:0] ST_DONE = 3'd6;

    typedef enum logic [2:0] {
        IDLE = ST_IDLE,
        ADDR = ST_ADDR,
        HOLD = ST_HOLD,
        TURN = ST_TURN,
        DATA = ST_DATA,
        REC  = ST_REC,
        DONE = ST_DONE
    } estado_t;

    localparam int T_ADDR_DEF = 4;
    localparam int T_HOLD_DEF = 2;
    localparam int T_DATA_DEF = 8;
    localparam int T_REC_DEF  = 4;
    localparam int CNT_W_DEF  = 4;

    typedef struct packed {
        logic cs_n;
        logic as_rtc;
        logic rd_n;
        logic wr_n;
        logic flag_dato;
        logic direccion_dato;
        logic controlador_dato;
        logic captura;
        logic busy;
        logic done;
    } salidas_t;

    // Idle/reset level of every output: strobes inactive, mux parked.
    localparam salidas_t SALIDAS_REPOSO = salidas_t'(10'b10_1100_0000);

    // Cycles from accepted start to the done cycle (inclusive), so the control
    // FSM can budget a whole access.
    function automatic int duracion_ciclo(input int ta, input int th,
                                          input int td, input int tr);
        return ta + th + 1 + td + tr + 1;
    endfunction

endpackage

// File: rtl/generador_ciclo_rtc.sv
// RTC multiplexed address/data bus-cycle sequencer (address, hold, turnaround,
// data, recovery, done). Optional watchdog/error output: RTC_TIMEOUT_CNT_EN.
module generador_ciclo_rtc
    import generador_ciclo_rtc_pkg::*;
#(
    parameter int T_ADDR = T_ADDR_DEF,
    parameter int T_HOLD = T_HOLD_DEF,
    parameter int T_DATA = T_DATA_DEF,
    parameter int T_REC  = T_REC_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic rw,
    output logic busy,
    output logic done,
`ifdef RTC_TIMEOUT_CNT_EN
    output logic error,
`endif
    output logic cs_n,
    output logic as_rtc,
    output logic rd_n,
    output logic wr_n,
    output logic flag_dato,
    output logic direccion_dato,
    output logic controlador_dato,
    output logic captura
);

    localparam logic [CNT_W-1:0] CARGA_ADDR = CNT_W'(T_ADDR - 1);
    localparam logic [CNT_W-1:0] CARGA_HOLD = CNT_W'(T_HOLD - 1);
    localparam logic [CNT_W-1:0] CARGA_DATA = CNT_W'(T_DATA - 1);
    localparam logic [CNT_W-1:0] CARGA_REC  = CNT_W'(T_REC - 1);
    localparam logic [CNT_W-1:0] UNO        = CNT_W'(1);

    estado_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             rw_q, rw_d;
    salidas_t         sal_q, sal_d;

`ifdef RTC_TIMEOUT_CNT_EN
    logic [7:0] wdog_q, wdog_d;
    logic       to_q, to_d;
    logic       error_q, error_d;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rw_d    = rw_q;
`ifdef RTC_TIMEOUT_CNT_EN
        to_d    = to_q;
        error_d = error_q;
        wdog_d  = (state_q == IDLE) ? 8'd0
                : (wdog_q == 8'hFF) ? wdog_q : wdog_q + 8'd1;
`endif
        if (state_q == IDLE) begin
            if (start) begin
                state_d = ADDR;
                cnt_d   = CARGA_ADDR;
                rw_d    = rw;
`ifdef RTC_TIMEOUT_CNT_EN
                to_d    = 1'b0;
                error_d = 1'b0;
`endif
            end
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - UNO;
        end else begin
            // Phase expired: load the length of the next phase on entry.
            case (state_q)
                ADDR:    begin state_d = HOLD; cnt_d = CARGA_HOLD; end
                HOLD:    begin state_d = TURN; cnt_d = '0;         end
                TURN:    begin state_d = DATA; cnt_d = CARGA_DATA; end
                DATA:    begin state_d = REC;  cnt_d = CARGA_REC;  end
                REC:     begin state_d = DONE; cnt_d = '0;         end
                DONE:    begin state_d = IDLE; cnt_d = '0;         end
                default: begin state_d = IDLE; cnt_d = '0;         end
            endcase
        end
`ifdef RTC_TIMEOUT_CNT_EN
        // Stuck cycle: release the bus through a one-cycle REC, then DONE.
        if (wdog_q == 8'd254 && (state_q == ADDR || state_q == HOLD ||
                                 state_q == TURN || state_q == DATA)) begin
            state_d = REC;
            cnt_d   = '0;
            to_d    = 1'b1;
        end
        if (state_d == DONE && (to_q || to_d)) error_d = 1'b1;
`endif
    end

    // Outputs are decoded from the next state so they switch on the same edge.
    always_comb begin
        sal_d = SALIDAS_REPOSO;
        case (state_d)
            ADDR: begin
                sal_d.cs_n = 1'b0; sal_d.as_rtc = 1'b1; sal_d.flag_dato = 1'b1;
                sal_d.controlador_dato = 1'b1; sal_d.busy = 1'b1;
            end
            HOLD: begin
                sal_d.cs_n = 1'b0; sal_d.flag_dato = 1'b1;
                sal_d.controlador_dato = 1'b1; sal_d.busy = 1'b1;
            end
            TURN: begin
                sal_d.cs_n = 1'b0; sal_d.direccion_dato = 1'b1; sal_d.busy = 1'b1;
            end
            DATA: begin
                sal_d.cs_n             = 1'b0;
                sal_d.flag_dato        = 1'b1;
                sal_d.direccion_dato   = 1'b1;
                sal_d.controlador_dato = rw_d;
                sal_d.wr_n             = ~rw_d;
                sal_d.rd_n             = rw_d;
                sal_d.captura          = ~rw_d && (cnt_d == '0);
                sal_d.busy             = 1'b1;
            end
            REC:  sal_d.busy = 1'b1;
            DONE: begin sal_d.busy = 1'b1; sal_d.done = 1'b1; end
            default: sal_d = SALIDAS_REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            sal_q   <= SALIDAS_REPOSO;
`ifdef RTC_TIMEOUT_CNT_EN
            wdog_q  <= 8'd0;
            to_q    <= 1'b0;
            error_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            sal_q   <= sal_d;
`ifdef RTC_TIMEOUT_CNT_EN
            wdog_q  <= wdog_d;
            to_q    <= to_d;
            error_q <= error_d;
`endif
        end
    end

    assign cs_n             = sal_q.cs_n;
    assign as_rtc           = sal_q.as_rtc;
    assign rd_n             = sal_q.rd_n;
    assign wr_n             = sal_q.wr_n;
    assign flag_dato        = sal_q.flag_dato;
    assign direccion_dato   = sal_q.direccion_dato;
    assign controlador_dato = sal_q.controlador_dato;
    assign captura          = sal_q.captura;
    assign busy             = sal_q.busy;
    assign done             = sal_q.done;
`ifdef RTC_TIMEOUT_CNT_EN
    assign error            = error_q;
`endif

endmodule

// File: tb/tb_generador_ciclo_rtc.sv
// Bench for generador_ciclo_rtc: default timing and minimum timing instances
// driven together and compared cycle by cycle against a timeline model.
module tb_generador_ciclo_rtc;

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic start = 1'b0;
    logic rw = 1'b0;

    logic [1:0] cs_n_w, as_w, rd_w, wr_w, flag_w, dir_w, ctrl_w, cap_w, busy_w, done_w;
`ifdef RTC_TIMEOUT_CNT_EN
    logic [1:0] err_w;
`endif

    int ta_p[2] = '{4, 1};
    int th_p[2] = '{2, 1};
    int td_p[2] = '{8, 2};
    int tr_p[2] = '{4, 1};

    int t_m[2];
    bit rw_m[2];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    generador_ciclo_rtc u_def (
        .clk(clk), .reset(reset), .start(start), .rw(rw),
        .busy(busy_w[0]), .done(done_w[0]),
`ifdef RTC_TIMEOUT_CNT_EN
        .error(err_w[0]),
`endif
        .cs_n(cs_n_w[0]), .as_rtc(as_w[0]), .rd_n(rd_w[0]), .wr_n(wr_w[0]),
        .flag_dato(flag_w[0]), .direccion_dato(dir_w[0]),
        .controlador_dato(ctrl_w[0]), .captura(cap_w[0])
    );

    generador_ciclo_rtc #(
        .T_ADDR(1), .T_HOLD(1), .T_DATA(2), .T_REC(1), .CNT_W(4)
    ) u_min (
        .clk(clk), .reset(reset), .start(start), .rw(rw),
        .busy(busy_w[1]), .done(done_w[1]),
`ifdef RTC_TIMEOUT_CNT_EN
        .error(err_w[1]),
`endif
        .cs_n(cs_n_w[1]), .as_rtc(as_w[1]), .rd_n(rd_w[1]), .wr_n(wr_w[1]),
        .flag_dato(flag_w[1]), .direccion_dato(dir_w[1]),
        .controlador_dato(ctrl_w[1]), .captura(cap_w[1])
    );

    task automatic check_eq(input string tag, input logic [9:0] obs, input logic [9:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s at %0t: observed=%b expected=%b", tag, $time, obs, exp);
        end
    endtask

    // Expected outputs from the position t within a request (0 = idle,
    // 1 = first cycle after acceptance). Order matches obs().
    function automatic logic [9:0] modelo(input int t, input bit w, input int ta,
                                          input int th, input int td, input int tr);
        int  d0, d1, tot;
        bit  a, h, tu, d;
        d0  = ta + th + 2;
        d1  = ta + th + 1 + td;
        tot = d1 + tr + 1;
        a   = (t >= 1) && (t <= ta);
        h   = (t > ta) && (t <= ta + th);
        tu  = (t == ta + th + 1);
        d   = (t >= d0) && (t <= d1);
        return {!(a || h || tu || d), a, !(d && !w), !(d && w), a || h || d,
                tu || d, a || h || (d && w), d && (t == d1) && !w, t != 0, t == tot};
    endfunction

    function automatic logic [9:0] obs(input int k);
        return {cs_n_w[k], as_w[k], rd_w[k], wr_w[k], flag_w[k], dir_w[k],
                ctrl_w[k], cap_w[k], busy_w[k], done_w[k]};
    endfunction

    task automatic avanzar(input int k);
        int tot;
        tot = ta_p[k] + th_p[k] + 1 + td_p[k] + tr_p[k] + 1;
        if (t_m[k] != 0) t_m[k] = (t_m[k] == tot) ? 0 : t_m[k] + 1;
        else if (start) begin
            t_m[k]  = 1;
            rw_m[k] = rw;
        end
    endtask

    task automatic comparar();
        for (int k = 0; k < 2; k++) begin
            check_eq($sformatf("outputs_u%0d", k), obs(k),
                     modelo(t_m[k], rw_m[k], ta_p[k], th_p[k], td_p[k], tr_p[k]));
            check_eq($sformatf("strobe_order_u%0d", k),
                     {7'd0, as_w[k] & cs_n_w[k], (~rd_w[k] | ~wr_w[k]) & cs_n_w[k],
                      ~rd_w[k] & ~wr_w[k]}, 10'd0);
        end
    endtask

    task automatic paso(input bit s, input bit r);
        start = s;
        rw    = r;
        @(posedge clk);
        for (int k = 0; k < 2; k++) avanzar(k);
        #1;
        comparar();
    endtask

    task automatic pulso_reset();
        reset = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            t_m[k]  = 0;
            rw_m[k] = 1'b0;
        end
        comparar();
        reset = 1'b1;
    endtask

    initial begin
        for (int k = 0; k < 2; k++) begin
            t_m[k]  = 0;
            rw_m[k] = 1'b0;
        end
        repeat (3) @(posedge clk);
        #1;
        comparar();
        reset = 1'b1;
        repeat (5) paso(1'b0, 1'b0);

        // Single write, then single read, with default and minimum timing.
        paso(1'b1, 1'b1);
        repeat (24) paso(1'b0, 1'b0);
        paso(1'b1, 1'b0);
        repeat (24) paso(1'b0, 1'b1);

        // start held high with rw toggling: back-to-back cycles.
        for (int i = 0; i < 50; i++) paso(1'b1, 1'(i % 3 == 0 ? 1 : $urandom_range(0, 1)));
        repeat (22) paso(1'b0, 1'b0);

        // Reset in the middle of a read data phase, then a clean read.
        paso(1'b1, 1'b0);
        for (int i = 0; i < 30 && t_m[0] != 11; i++) paso(1'b0, 1'b0);
        pulso_reset();
        repeat (3) paso(1'b0, 1'b0);
        paso(1'b1, 1'b0);
        repeat (22) paso(1'b0, 1'b0);

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 800; i++) begin
            paso(1'($urandom_range(0, 3) == 0), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 59) == 0) pulso_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
